// File: rtl/ex_stage_mdu_if.sv
// ex_stage_mdu_if: ID->EX operand bundle, pipeline controls and EX/MEM outputs.
// master drives the ID side, slave is the execute stage.
interface ex_stage_mdu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 30,
  parameter int REG_AW = 5
);
  logic              stall;
  logic              flush;
  logic              int_detect;
  logic              id_en;
  logic [ADDR_W-1:0] id_pc;
  logic [3:0]        id_op;
  logic [DATA_W-1:0] id_alu_in_0;
  logic [DATA_W-1:0] id_alu_in_1;
  logic [REG_AW-1:0] id_dst_addr;
  logic              id_gpr_we_;
  logic              mdu_busy;
  logic [DATA_W-1:0] fwd_data;
  logic              ex_en;
  logic [ADDR_W-1:0] ex_pc;
  logic [REG_AW-1:0] ex_dst_addr;
  logic              ex_gpr_we_;
  logic [DATA_W-1:0] ex_out;
  logic              ex_of;

  modport master (
    output stall, flush, int_detect, id_en, id_pc, id_op,
    output id_alu_in_0, id_alu_in_1, id_dst_addr, id_gpr_we_,
    input  mdu_busy, fwd_data, ex_en, ex_pc, ex_dst_addr,
    input  ex_gpr_we_, ex_out, ex_of
  );

  modport slave (
    input  stall, flush, int_detect, id_en, id_pc, id_op,
    input  id_alu_in_0, id_alu_in_1, id_dst_addr, id_gpr_we_,
    output mdu_busy, fwd_data, ex_en, ex_pc, ex_dst_addr,
    output ex_gpr_we_, ex_out, ex_of
  );
endinterface

// File: rtl/ex_stage_mdu.sv
// ex_stage_mdu: ALU + iterative MUL/DIV unit with EX/MEM register.
// Optional MDU_EARLY_OUT_EN: zero-operand MDU ops skip the iterations.
module ex_stage_mdu #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 30,
  parameter int REG_AW = 5
) (
  input logic           clk,
  input logic           reset,
  ex_stage_mdu_if.slave pipe
);
  localparam int SHAMT_W = $clog2(DATA_W);
  localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(DATA_W - 1);
  localparam int M = DATA_W - 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   a, b, sum, diff;
  logic [SHAMT_W-1:0]  shamt;
  logic [3:0]          op;
  logic                kill, is_mul, is_mdu, issue, early;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_of;
  logic [DATA_W-1:0]   hi_q, lo_q, b_q;
  logic                mul_q, sel_hi_q;
  logic [SHAMT_W-1:0]  cnt_q;
  logic [DATA_W-1:0]   hi_n, lo_n, mcand, e_hi, e_lo;
  logic [DATA_W:0]     madd, rsh;
  logic [DATA_W-1:0]   rsub, mdu_res;
  logic                ge;
  logic                busy;
  logic [DATA_W-1:0]   fwd;
  logic                ex_en_q, ex_we_q, ex_of_q;
  logic [ADDR_W-1:0]   ex_pc_q;
  logic [REG_AW-1:0]   ex_dst_q;
  logic [DATA_W-1:0]   ex_out_q;

  assign a      = pipe.id_alu_in_0;
  assign b      = pipe.id_alu_in_1;
  assign op     = pipe.id_op;
  assign shamt  = b[SHAMT_W-1:0];
  assign sum    = a + b;
  assign diff   = a - b;
  assign kill   = pipe.flush | pipe.int_detect;
  assign is_mul = (op == 4'd9) || (op == 4'd10);
  assign is_mdu = (op >= 4'd9) && (op <= 4'd12);
  assign issue  = (state_q == IDLE) && pipe.id_en && is_mdu
                  && !kill && !reset;

`ifdef MDU_EARLY_OUT_EN
  assign early = (b == '0) || (is_mul && (a == '0));
  assign e_hi  = is_mul ? '0 : a;
  assign e_lo  = is_mul ? '0 : '1;
`else
  assign early = 1'b0;
  assign e_hi  = '0;
  assign e_lo  = '0;
`endif

  // single-cycle ALU result and signed overflow
  always_comb begin
    alu_res = '0;
    alu_of  = 1'b0;
    case (op)
      4'd0: alu_res = a;
      4'd1: begin
        alu_res = sum;
        alu_of  = (a[M] == b[M]) && (sum[M] != a[M]);
      end
      4'd2: begin
        alu_res = diff;
        alu_of  = (a[M] != b[M]) && (diff[M] != a[M]);
      end
      4'd3: alu_res = a & b;
      4'd4: alu_res = a | b;
      4'd5: alu_res = a ^ b;
      4'd6: alu_res = a << shamt;
      4'd7: alu_res = a >> shamt;
      4'd8: alu_res = $signed(a) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  // one shift-add or restoring-divide step on {hi,lo}
  assign mcand = lo_q[0] ? b_q : '0;
  assign madd  = {1'b0, hi_q} + {1'b0, mcand};
  assign rsh   = {hi_q, lo_q[M]};
  assign ge    = rsh >= {1'b0, b_q};
  assign rsub  = rsh[DATA_W-1:0] - b_q;

  always_comb begin
    if (mul_q) begin
      hi_n = madd[DATA_W:1];
      lo_n = {madd[0], lo_q[M:1]};
    end else begin
      hi_n = ge ? rsub : rsh[DATA_W-1:0];
      lo_n = {lo_q[M-1:0], ge};
    end
  end

  assign mdu_res = sel_hi_q ? hi_q : lo_q;

  // MDU operand/accumulator registers
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      mul_q    <= 1'b0;
      sel_hi_q <= 1'b0;
      cnt_q    <= '0;
    end else if (issue) begin
      b_q      <= b;
      mul_q    <= is_mul;
      sel_hi_q <= (op == 4'd10) || (op == 4'd12);
      cnt_q    <= '0;
      hi_q     <= early ? e_hi : '0;
      lo_q     <= early ? e_lo : a;
    end else if (state_q == BUSY) begin
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      cnt_q <= cnt_q + SHAMT_W'(1);
    end
  end

  // MDU state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // MDU next-state
  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (issue) state_d = early ? DONE : BUSY;
        BUSY: if (cnt_q == CNT_LAST) state_d = DONE;
        DONE: if (!pipe.stall) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // MDU outputs: busy indication and forwarding mux
  always_comb begin
    busy = 1'b0;
    fwd  = alu_res;
    unique case (state_q)
      IDLE: begin
        busy = issue;
        fwd  = alu_res;
      end
      BUSY: begin
        busy = !kill;
        fwd  = '0;
      end
      DONE: begin
        busy = 1'b0;
        fwd  = mdu_res;
      end
      default: begin
        busy = 1'b0;
        fwd  = '0;
      end
    endcase
  end

  // EX/MEM pipeline register
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_en_q  <= 1'b0;
      ex_we_q  <= 1'b1;
      ex_of_q  <= 1'b0;
      ex_pc_q  <= '0;
      ex_dst_q <= '0;
      ex_out_q <= '0;
    end else if (kill || (busy && !pipe.stall)) begin
      ex_en_q <= 1'b0;
      ex_we_q <= 1'b1;
      ex_of_q <= 1'b0;
    end else if (!pipe.stall) begin
      ex_en_q  <= pipe.id_en;
      ex_pc_q  <= pipe.id_pc;
      ex_dst_q <= pipe.id_dst_addr;
      ex_out_q <= fwd;
      ex_of_q  <= pipe.id_en && alu_of;
      ex_we_q  <= !pipe.id_en || pipe.id_gpr_we_ || alu_of;
    end
  end

  assign pipe.mdu_busy    = busy;
  assign pipe.fwd_data    = fwd;
  assign pipe.ex_en       = ex_en_q;
  assign pipe.ex_pc       = ex_pc_q;
  assign pipe.ex_dst_addr = ex_dst_q;
  assign pipe.ex_gpr_we_  = ex_we_q;
  assign pipe.ex_out      = ex_out_q;
  assign pipe.ex_of       = ex_of_q;
endmodule

// File: tb/tb_ex_stage_mdu.sv
// tb_ex_stage_mdu: directed vectors, scoreboard queue checked by a monitor.
// Honours MDU_EARLY_OUT_EN for the expected busy lengths.
module tb_ex_stage_mdu;
  localparam int DW = 32;
  localparam int AW = 30;
  localparam int RW = 5;
`ifdef MDU_EARLY_OUT_EN
  localparam int BZ = 1;
`else
  localparam int BZ = 33;
`endif

  typedef struct {
    logic [31:0] out;
    logic        of;
    logic        we;
    logic [4:0]  dst;
    logic [29:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic ld = 1'b0;
  int tests = 0;
  int fails = 0;
  exp_t sbq[$];
  logic [29:0] pcv = 30'h100;

  always #5 clk = ~clk;

  ex_stage_mdu_if #(.DATA_W(DW), .ADDR_W(AW), .REG_AW(RW)) bus ();

  ex_stage_mdu #(.DATA_W(DW), .ADDR_W(AW), .REG_AW(RW)) dut (
    .clk  (clk),
    .reset(reset),
    .pipe (bus)
  );

  always @(posedge clk)
    ld = !reset && !bus.flush && !bus.int_detect && !bus.stall;

  always @(negedge clk) begin
    exp_t e;
    if (ld && bus.ex_en) begin
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL sb_extra: got ex_out=%h pc=%h, want no valid output",
                 bus.ex_out, bus.ex_pc);
      end else begin
        e = sbq.pop_front();
        if (bus.ex_out !== e.out || bus.ex_of !== e.of ||
            bus.ex_gpr_we_ !== e.we || bus.ex_dst_addr !== e.dst ||
            bus.ex_pc !== e.pc) begin
          fails++;
          $display("FAIL sb_pc%h: got out=%h of=%b we=%b dst=%0d pc=%h, want out=%h of=%b we=%b dst=%0d pc=%h",
                   e.pc, bus.ex_out, bus.ex_of, bus.ex_gpr_we_,
                   bus.ex_dst_addr, bus.ex_pc, e.out, e.of, e.we, e.dst, e.pc);
        end
      end
    end
  end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic set_id(logic en, logic [3:0] op, logic [31:0] a,
                        logic [31:0] b, logic [4:0] dst,
                        logic [29:0] pc, logic we_n);
    bus.id_en       = en;
    bus.id_op       = op;
    bus.id_alu_in_0 = a;
    bus.id_alu_in_1 = b;
    bus.id_dst_addr = dst;
    bus.id_pc       = pc;
    bus.id_gpr_we_  = we_n;
  endtask

  task automatic idle();
    set_id(1'b0, 4'd0, 32'h0000_55AA, 32'h0, 5'd0, 30'h0, 1'b1);
  endtask

  task automatic alu(string nm, logic [3:0] op, logic [31:0] a,
                     logic [31:0] b, logic [31:0] r, logic of);
    pcv = pcv + 30'd1;
    set_id(1'b1, op, a, b, pcv[4:0], pcv, 1'b0);
    #1 chk({nm, "_fwd"}, bus.fwd_data, r);
    sbq.push_back(exp_t'{r, of, of, pcv[4:0], pcv});
    @(posedge clk);
    #2;
  endtask

  task automatic mdu(string nm, logic [3:0] op, logic [31:0] a,
                     logic [31:0] b, logic [31:0] r, int bexp, int stall_n);
    int  n = 0;
    bit  bad = 1'b0;
    bit  done = 1'b0;
    bit  sbad = 1'b0;
    pcv = pcv + 30'd1;
    set_id(1'b1, op, a, b, pcv[4:0], pcv, 1'b0);
    sbq.push_back(exp_t'{r, 1'b0, 1'b0, pcv[4:0], pcv});
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!bus.mdu_busy) begin
        done = 1'b1;
        break;
      end
      if (n > 0 && bus.ex_en) bad = 1'b1;
      n++;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: mdu_busy still 1 after 200 cycles, want 0", nm);
    end
    chk({nm, "_busy"}, 32'(n), 32'(bexp));
    chk({nm, "_bubble"}, 32'(bad), 32'd0);
    if (stall_n > 0) begin
      bus.stall = 1'b1;
      repeat (stall_n) begin
        @(posedge clk);
        #1;
        if (bus.mdu_busy || bus.ex_en) sbad = 1'b1;
      end
      chk({nm, "_stall_hold"}, 32'(sbad), 32'd0);
      bus.stall = 1'b0;
    end
    @(posedge clk);
    #2;
    idle();
    @(negedge clk);
    chk({nm, "_no_reissue"}, 32'(bus.mdu_busy), 32'd0);
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset          = 1'b1;
    bus.stall      = 1'b0;
    bus.flush      = 1'b0;
    bus.int_detect = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", 32'(bus.ex_en), 32'd0);
    chk("rst_we", 32'(bus.ex_gpr_we_), 32'd1);
    chk("rst_out", bus.ex_out, 32'd0);
    chk("rst_busy", 32'(bus.mdu_busy), 32'd0);
    #1 reset = 1'b0;

    alu("add_of", 4'd1, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1);
    alu("sub_of", 4'd2, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b1);
    alu("add", 4'd1, 32'd3, 32'd4, 32'd7, 1'b0);
    alu("thru", 4'd0, 32'h1234_5678, 32'h9, 32'h1234_5678, 1'b0);
    alu("and", 4'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0);
    alu("or", 4'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0);
    alu("xor", 4'd5, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0);
    alu("sll", 4'd6, 32'h1, 32'h24, 32'h10, 1'b0);
    alu("srl", 4'd7, 32'h8000_0000, 32'd31, 32'h1, 1'b0);
    alu("sra", 4'd8, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
    alu("op13", 4'd13, 32'h5, 32'h6, 32'h0, 1'b0);
    idle();
    @(posedge clk);
    #2;

    mdu("mul", 4'd9, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, 33, 0);
    mdu("mulhu", 4'd10, 32'hFFFF_FFFF, 32'h2, 32'h1, 33, 0);
    mdu("divu", 4'd11, 32'd100, 32'd7, 32'd14, 33, 0);
    mdu("remu", 4'd12, 32'd100, 32'd7, 32'd2, 33, 0);
    mdu("divu0", 4'd11, 32'd5, 32'd0, 32'hFFFF_FFFF, BZ, 0);
    mdu("remu0", 4'd12, 32'd5, 32'd0, 32'd5, BZ, 0);

    pcv = pcv + 30'd1;
    set_id(1'b1, 4'd11, 32'd1000, 32'd3, pcv[4:0], pcv, 1'b0);
    repeat (10) @(posedge clk);
    #2 bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_busy", 32'(bus.mdu_busy), 32'd0);
    @(posedge clk);
    #1;
    chk("flush_en", 32'(bus.ex_en), 32'd0);
    chk("flush_we", 32'(bus.ex_gpr_we_), 32'd1);
    #1 bus.flush = 1'b0;
    alu("flush_add", 4'd1, 32'd3, 32'd4, 32'd7, 1'b0);
    idle();
    @(posedge clk);
    #2;

    mdu("mul_stall", 4'd9, 32'd6, 32'd7, 32'd42, 33, 3);

    pcv = pcv + 30'd1;
    set_id(1'b1, 4'd9, 32'd6, 32'd7, pcv[4:0], pcv, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    idle();
    @(posedge clk);
    #1;
    chk("rst2_en", 32'(bus.ex_en), 32'd0);
    chk("rst2_out", bus.ex_out, 32'd0);
    chk("rst2_we", 32'(bus.ex_gpr_we_), 32'd1);
    chk("rst2_of", 32'(bus.ex_of), 32'd0);
    chk("rst2_pc", 32'(bus.ex_pc), 32'd0);
    chk("rst2_busy", 32'(bus.mdu_busy), 32'd0);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
